// File: rtl/hartslag_filter.sv
// hartslag_filter: conditions the raw heartbeat sensor line into one clean
// single-cycle Puls per beat. Two-flop synchroniser, debounce FSM, refractory
// window, beat-to-beat interval measurement and a no-heartbeat timeout flag.
//
// Debounce FSM states:
//   state | meaning
//   LAAG  | debounced level low, waiting for the line to rise
//   STIJG | line high, counting stable cycles before accepting the rise
//   HOOG  | debounced level high, waiting for the line to fall
//   DAAL  | line low, counting stable cycles before accepting the fall
module hartslag_filter #(
  parameter int unsigned CNT_W    = 28,
  parameter int unsigned DB_W     = 16,
  parameter int unsigned DEBOUNCE = 50000,
  parameter int unsigned REFRACT  = 15000000,
  parameter int unsigned TIMEOUT  = 150000000
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Sensor,
  output logic             Puls,
  output logic             Afgewezen,
  output logic [CNT_W-1:0] Interval,
  output logic             IntervalGeldig,
  output logic             GeenSlag
);

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] REF_C   = CNT_W'(REFRACT);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    LAAG  = 2'd0,
    STIJG = 2'd1,
    HOOG  = 2'd2,
    DAAL  = 2'd3
  } db_state_e;

  logic             sync1_q, sync2_q;
  db_state_e        state_q, state_d;
  logic [DB_W-1:0]  dc_q, dc_d;
  logic             rise_edge;

  logic             eerste_q, eerste_d;
  logic [CNT_W-1:0] sinds_q, sinds_d;
  logic             puls_q, puls_d;
  logic             afg_q, afg_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic             geldig_q, geldig_d;
  logic             geen_q, geen_d;

  // Bring the asynchronous sensor line into the clock domain.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= Sensor;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state and stability counter registers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= LAAG;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
    end
  end

  // Debounce next-state: a level change is accepted only after the
  // synchronised line has held the new level for DEBOUNCE further cycles.
  always_comb begin
    state_d   = state_q;
    dc_d      = dc_q;
    rise_edge = 1'b0;
    unique case (state_q)
      LAAG: begin
        if (sync2_q) begin
          state_d = STIJG;
          dc_d    = DB_ONE;
        end
      end
      STIJG: begin
        if (!sync2_q) begin
          state_d = LAAG;
          dc_d    = '0;
        end else if (dc_q == DB_MAX) begin
          state_d   = HOOG;
          dc_d      = '0;
          rise_edge = 1'b1;
        end else begin
          dc_d = dc_q + DB_ONE;
        end
      end
      HOOG: begin
        if (!sync2_q) begin
          state_d = DAAL;
          dc_d    = DB_ONE;
        end
      end
      DAAL: begin
        // A bounce back high during the fall returns to HOOG without a new edge.
        if (sync2_q) begin
          state_d = HOOG;
          dc_d    = '0;
        end else if (dc_q == DB_MAX) begin
          state_d = LAAG;
          dc_d    = '0;
        end else begin
          dc_d = dc_q + DB_ONE;
        end
      end
      default: begin
        state_d = LAAG;
        dc_d    = '0;
      end
    endcase
  end

  // Beat acceptance, refractory rejection, interval capture and timeout.
  always_comb begin
    puls_d     = 1'b0;
    afg_d      = 1'b0;
    eerste_d   = eerste_q;
    interval_d = interval_q;
    geldig_d   = geldig_q;
    geen_d     = geen_q;

    if (rise_edge) begin
      if (eerste_q) begin
        puls_d   = 1'b1;
        eerste_d = 1'b0;
      end else if (sinds_q < REF_C) begin
        afg_d = 1'b1;
      end else begin
        puls_d = 1'b1;
        // A beat ending a timeout gap restarts timing but is not a measurement.
        if (!geen_q) begin
          interval_d = sinds_q + CNT_ONE;
          geldig_d   = 1'b1;
        end
      end
    end

    if (puls_d) begin
      sinds_d = '0;
    end else if (sinds_q < TO_C) begin
      sinds_d = sinds_q + CNT_ONE;
    end else begin
      sinds_d = sinds_q;
    end

    // GeenSlag rises together with Sinds reaching TIMEOUT, so an accepted
    // measurement can never exceed TIMEOUT.
    if (puls_d) begin
      geen_d = 1'b0;
    end else if (!eerste_q && (sinds_d == TO_C)) begin
      geen_d   = 1'b1;
      geldig_d = 1'b0;
    end
  end

  // Registered beat outputs and timing state.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      eerste_q   <= 1'b1;
      sinds_q    <= '0;
      puls_q     <= 1'b0;
      afg_q      <= 1'b0;
      interval_q <= '0;
      geldig_q   <= 1'b0;
      geen_q     <= 1'b0;
    end else begin
      eerste_q   <= eerste_d;
      sinds_q    <= sinds_d;
      puls_q     <= puls_d;
      afg_q      <= afg_d;
      interval_q <= interval_d;
      geldig_q   <= geldig_d;
      geen_q     <= geen_d;
    end
  end

  assign Puls           = puls_q;
  assign Afgewezen      = afg_q;
  assign Interval       = interval_q;
  assign IntervalGeldig = geldig_q;
  assign GeenSlag       = geen_q;

  // Accept and reject strobes are mutually exclusive.
  a_puls_afg_excl: assert property (@(posedge CLK) disable iff (!Reset_n)
    !(puls_q && afg_q));

  // The measured interval is bounded by the saturating timer.
  a_interval_max: assert property (@(posedge CLK) disable iff (!Reset_n)
    interval_q <= TO_C);

endmodule

// File: tb/tb_hartslag_filter.sv
module tb_hartslag_filter;

  localparam int CNT_W    = 8;
  localparam int DB_W     = 8;
  localparam int DEBOUNCE = 4;
  localparam int REFRACT  = 20;
  localparam int TIMEOUT  = 100;

  logic             CLK = 1'b0;
  logic             Reset_n = 1'b0;
  logic             Sensor = 1'b0;
  logic             Puls;
  logic             Afgewezen;
  logic [CNT_W-1:0] Interval;
  logic             IntervalGeldig;
  logic             GeenSlag;

  hartslag_filter #(
    .CNT_W(CNT_W), .DB_W(DB_W), .DEBOUNCE(DEBOUNCE),
    .REFRACT(REFRACT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Sensor(Sensor),
    .Puls(Puls), .Afgewezen(Afgewezen), .Interval(Interval),
    .IntervalGeldig(IntervalGeldig), .GeenSlag(GeenSlag)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: sample history, debounced level, run length of disagreeing samples.
  int h1, h2, lvl, run, m_first, last_t, k, s, ev;
  int e_puls = 0, e_afg = 0, e_int = 0, e_geldig = 0, e_geen = 0;

  int dut_puls_cnt = 0, dut_afg_cnt = 0, dut_last_puls = 0;
  int t0, p0, a0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update on each rising edge, then compare the DUT shortly after.
  always @(posedge CLK) begin
    cyc++;
    if (!Reset_n) begin
      h1 = 0; h2 = 0; lvl = 0; run = 0; m_first = 1; last_t = 0;
      e_puls = 0; e_afg = 0; e_int = 0; e_geldig = 0; e_geen = 0;
    end else begin
      s  = h2;
      h2 = h1;
      h1 = int'(Sensor);
      ev = 0;
      if (s != lvl) run++; else run = 0;
      if (run == DEBOUNCE + 1) begin
        lvl = s;
        run = 0;
        ev  = s;
      end
      e_puls = 0;
      e_afg  = 0;
      if (ev != 0) begin
        k = cyc - last_t;
        if (m_first != 0) begin
          e_puls = 1; m_first = 0; last_t = cyc; e_geen = 0;
        end else if (k <= REFRACT) begin
          e_afg = 1;
        end else begin
          e_puls = 1;
          if (k <= TIMEOUT) begin
            e_int = k;
            e_geldig = 1;
          end
          last_t = cyc;
          e_geen = 0;
        end
      end
      if (e_puls == 0 && m_first == 0 && (cyc - last_t) >= TIMEOUT) begin
        e_geen = 1;
        e_geldig = 0;
      end
    end
    #1;
    chk("Puls", int'(Puls), e_puls);
    chk("Afgewezen", int'(Afgewezen), e_afg);
    chk("Interval", int'(Interval), e_int);
    chk("IntervalGeldig", int'(IntervalGeldig), e_geldig);
    chk("GeenSlag", int'(GeenSlag), e_geen);
    if (Puls) begin
      dut_puls_cnt++;
      dut_last_puls = cyc;
    end
    if (Afgewezen) dut_afg_cnt++;
  end

  task automatic beat(input int hi, input int lo);
    Sensor = 1'b1;
    repeat (hi) @(negedge CLK);
    Sensor = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    chk("rst_puls", int'(Puls), 0);
    chk("rst_interval", int'(Interval), 0);
    chk("rst_geenslag", int'(GeenSlag), 0);

    // 1: reset in the middle of a debounce, no pulse on release
    Sensor = 1'b1;
    repeat (3) @(negedge CLK);
    Reset_n = 1'b0;
    @(negedge CLK);
    Sensor = 1'b0;
    @(negedge CLK);
    Reset_n = 1'b1;
    repeat (20) @(negedge CLK);
    chk("t1_no_puls", dut_puls_cnt, 0);

    // 2: short glitch ignored, then a real beat with fixed latency
    do_reset();
    p0 = dut_puls_cnt;
    beat(3, 10);
    chk("t2_glitch", dut_puls_cnt - p0, 0);
    t0 = cyc + 1;
    beat(5, 10);
    chk("t2_puls_cnt", dut_puls_cnt - p0, 1);
    chk("t2_latency", dut_last_puls - t0, 6);

    // 3: two beats 30 cycles apart
    do_reset();
    p0 = dut_puls_cnt;
    beat(5, 25);
    beat(5, 25);
    chk("t3_puls_cnt", dut_puls_cnt - p0, 2);
    chk("t3_interval", int'(Interval), 30);
    chk("t3_geldig", int'(IntervalGeldig), 1);

    // 4: second beat inside refractory window
    do_reset();
    p0 = dut_puls_cnt; a0 = dut_afg_cnt;
    beat(5, 5);
    beat(5, 10);
    chk("t4_puls_cnt", dut_puls_cnt - p0, 1);
    chk("t4_afg_cnt", dut_afg_cnt - a0, 1);
    chk("t4_interval", int'(Interval), 0);

    // 5: timeout, recovery beat, then fresh measurement
    do_reset();
    beat(5, 25);
    beat(5, 25);
    repeat (90) @(negedge CLK);
    chk("t5_geenslag", int'(GeenSlag), 1);
    chk("t5_geldig_lost", int'(IntervalGeldig), 0);
    beat(5, 35);
    chk("t5_geen_clear", int'(GeenSlag), 0);
    chk("t5_geldig_gap", int'(IntervalGeldig), 0);
    chk("t5_interval_kept", int'(Interval), 30);
    beat(5, 35);
    chk("t5_interval", int'(Interval), 40);
    chk("t5_geldig", int'(IntervalGeldig), 1);

    // 6: bounce every cycle
    p0 = dut_puls_cnt; a0 = dut_afg_cnt;
    for (int i = 0; i < 50; i++) begin
      Sensor = ~Sensor;
      @(negedge CLK);
    end
    Sensor = 1'b0;
    repeat (10) @(negedge CLK);
    chk("t6_no_puls", dut_puls_cnt - p0, 0);
    chk("t6_no_afg", dut_afg_cnt - a0, 0);

    // 7: refractory boundary, 20 rejected and 21 accepted
    do_reset();
    a0 = dut_afg_cnt;
    beat(5, 15);
    beat(5, 16);
    chk("t7_afg_at_20", dut_afg_cnt - a0, 1);
    do_reset();
    beat(5, 16);
    beat(5, 10);
    chk("t7_interval_21", int'(Interval), 21);

    // 8: timeout boundary, 100 measured and 101 not
    do_reset();
    beat(5, 95);
    beat(5, 10);
    chk("t8_interval_100", int'(Interval), 100);
    chk("t8_geldig_100", int'(IntervalGeldig), 1);
    do_reset();
    beat(5, 96);
    beat(5, 10);
    chk("t8_geldig_101", int'(IntervalGeldig), 0);
    chk("t8_geen_101", int'(GeenSlag), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
